// File: rtl/dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler
// Brief    : Turns one queued request at a time into an ACT/RD/WR/PRE command
//            sequence under an open-page policy over 32 banks (8 BG x 4 BA).
//            It enforces tRCD, tRP, tRAS and CAS latency, counted in cpu_clk
//            cycles.
// Options  : MC_REFRESH_EN adds periodic PREA/REF refresh with tREFI/tRFC.
// Revision : 1.0 - initial release
// ============================================================================
module dram_cmd_scheduler #(
  parameter int T_RCD   = 78,
  parameter int T_RP    = 78,
  parameter int T_RAS   = 152,
  parameter int T_CL    = 80,
  parameter int T_CWL   = 76,
  parameter int T_BURST = 16,
  parameter int T_REFI  = 7800,
  parameter int T_RFC   = 590
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [33:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0]  OP_NOP   = 3'd0;
  localparam logic [2:0]  OP_ACT   = 3'd1;
  localparam logic [2:0]  OP_RD    = 3'd2;
  localparam logic [2:0]  OP_WR    = 3'd3;
  localparam logic [2:0]  OP_PRE   = 3'd4;
  localparam logic [15:0] RCD_LOAD = 16'(T_RCD - 1);
  localparam logic [15:0] RP_LOAD  = 16'(T_RP - 1);
  localparam logic [15:0] CL_LOAD  = 16'(T_CL + T_BURST - 1);
  localparam logic [15:0] CWL_LOAD = 16'(T_CWL + T_BURST - 1);
  localparam logic [63:0] RAS_MIN  = 64'(T_RAS);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DATA,
    S_DONE, S_REF_RAS, S_PREA, S_WAIT_PREA, S_REF, S_WAIT_RFC
  } state_t;

  state_t      state, state_next;
  logic [63:0] now;
  logic [15:0] wait_cnt;
  logic        wait_zero;
  logic        lat_write, lat_channel;
  logic [2:0]  lat_bg;
  logic [1:0]  lat_ba;
  logic [15:0] lat_row;
  logic [9:0]  lat_col;
  logic [4:0]  bank;
  logic [31:0] bank_open;
  logic [15:0] bank_row [32];   // meaningful only while the bank is open
  logic [63:0] bank_act [32];   // meaningful only while the bank is open
  logic        row_hit, ras_ok, accept;
  logic        unused_bits;

  assign bank      = {lat_bg, lat_ba};
  assign row_hit   = bank_open[bank] && (bank_row[bank] == lat_row);
  assign ras_ok    = (now - bank_act[bank]) >= RAS_MIN;
  assign wait_zero = (wait_cnt == 16'd0);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign cmd_valid = (cmd_op != OP_NOP);

`ifdef MC_REFRESH_EN
  localparam logic [2:0]  OP_PREA   = 3'd5;
  localparam logic [2:0]  OP_REF    = 3'd6;
  localparam logic [15:0] RFC_LOAD  = 16'(T_RFC - 1);
  localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

  logic [15:0] ref_cnt;
  logic        ref_pending;
  logic        all_ras_ok;

  assign req_ready   = (state == S_IDLE) && !rst && !ref_pending;
  assign unused_bits = ^req_addr[1:0];

  // Every open bank must have honoured tRAS before the all-bank precharge.
  always_comb begin
    all_ras_ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (bank_open[b] && ((now - bank_act[b]) < RAS_MIN)) all_ras_ok = 1'b0;
    end
  end

  // Refresh interval timer; the pending flag is cleared once tRFC has elapsed.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (state == S_WAIT_RFC && wait_zero) ref_pending <= 1'b0;
      if (ref_cnt == REFI_LAST) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 16'd1;
      end
    end
  end
`else
  assign req_ready   = (state == S_IDLE) && !rst;
  assign unused_bits = ^{req_addr[1:0], 32'(T_REFI), 32'(T_RFC)};
`endif

  // Next-state and command decode; a command field is driven only with its op.
  always_comb begin
    state_next  = state;
    cmd_op      = OP_NOP;
    cmd_channel = 1'b0;
    cmd_bg      = 3'd0;
    cmd_ba      = 2'd0;
    cmd_row     = 16'd0;
    cmd_col     = 10'd0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_CHECK;
`ifdef MC_REFRESH_EN
        if (ref_pending) state_next = S_REF_RAS;
`endif
      end
      S_CHECK: begin
        if (row_hit)              state_next = S_RW;
        else if (bank_open[bank]) state_next = S_PRE;
        else                      state_next = S_ACT;
      end
      S_PRE: begin
        if (ras_ok) begin
          state_next  = S_WAIT_RP;
          cmd_op      = OP_PRE;
          cmd_channel = lat_channel;
          cmd_bg      = lat_bg;
          cmd_ba      = lat_ba;
        end
      end
      S_WAIT_RP:  if (wait_zero) state_next = S_ACT;
      S_ACT: begin
        state_next  = S_WAIT_RCD;
        cmd_op      = OP_ACT;
        cmd_channel = lat_channel;
        cmd_bg      = lat_bg;
        cmd_ba      = lat_ba;
        cmd_row     = lat_row;
      end
      S_WAIT_RCD: if (wait_zero) state_next = S_RW;
      S_RW: begin
        state_next  = S_WAIT_DATA;
        cmd_op      = lat_write ? OP_WR : OP_RD;
        cmd_channel = lat_channel;
        cmd_bg      = lat_bg;
        cmd_ba      = lat_ba;
        cmd_col     = lat_col;
      end
      S_WAIT_DATA: if (wait_zero) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
`ifdef MC_REFRESH_EN
      S_REF_RAS:   if (all_ras_ok) state_next = S_PREA;
      S_PREA: begin
        state_next = S_WAIT_PREA;
        cmd_op     = OP_PREA;
      end
      S_WAIT_PREA: if (wait_zero) state_next = S_REF;
      S_REF: begin
        state_next = S_WAIT_RFC;
        cmd_op     = OP_REF;
      end
      S_WAIT_RFC:  if (wait_zero) state_next = S_IDLE;
`endif
      default:     state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Free-running timestamp used for the tRAS check.
  always_ff @(posedge cpu_clk) begin
    if (rst) now <= '0;
    else     now <= now + 64'd1;
  end

  // Delay counter: loaded as each timed command issues, counts down otherwise.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      case (state)
        S_PRE:  if (ras_ok) wait_cnt <= RP_LOAD;
        S_ACT:  wait_cnt <= RCD_LOAD;
        S_RW:   wait_cnt <= lat_write ? CWL_LOAD : CL_LOAD;
`ifdef MC_REFRESH_EN
        S_PREA: wait_cnt <= RP_LOAD;
        S_REF:  wait_cnt <= RFC_LOAD;
`endif
        default: if (!wait_zero) wait_cnt <= wait_cnt - 16'd1;
      endcase
    end
  end

  // Capture the decoded request fields on the accept edge only.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      lat_write   <= 1'b0;
      lat_channel <= 1'b0;
      lat_bg      <= 3'd0;
      lat_ba      <= 2'd0;
      lat_row     <= 16'd0;
      lat_col     <= 10'd0;
    end else if (accept) begin
      lat_write   <= req_write;
      lat_channel <= req_addr[6];
      lat_bg      <= req_addr[9:7];
      lat_ba      <= req_addr[11:10];
      lat_row     <= req_addr[33:18];
      lat_col     <= {req_addr[17:12], req_addr[5:2]};
    end
  end

  // Open-page table: PRE closes a bank, ACT opens it and stamps the row/time.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      bank_open <= '0;
    end else if (state == S_PRE && ras_ok) begin
      bank_open[bank] <= 1'b0;
    end else if (state == S_ACT) begin
      bank_open[bank] <= 1'b1;
      bank_row[bank]  <= lat_row;
      bank_act[bank]  <= now;
`ifdef MC_REFRESH_EN
    end else if (state == S_REF) begin
      bank_open <= '0;
`endif
    end
  end

endmodule
`default_nettype wire
